// File: rtl/v_tx_text.sv
// Text-to-chunk encoder for the chunked TX path: byte 0 carries the text length,
// bytes 1..length carry the text, everything above is zero; held until acknowledged.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | ready for a request; oversize requests are rejected here
//   ST_BUILD | one cycle: encode the latched text into the chunk registers
//   ST_SEND  | chunk presented to the sender, waiting for tx_chunk_ack
//   ST_DONE  | one cycle of turnaround before accepting the next request
module v_tx_text #(
   parameter logic [7:0] INTERFACE_TX_CHUNK_TYPE      = 8'd5,
   parameter int         TX_CONTENT_BUFFER_BYTE_SIZE  = 33,
   parameter int         TX_CONTENT_BUFFER_INDEX_SIZE = 32,
   parameter int         TX_TEXT_MAX_SIZE             = 32
) (
   input  logic                                        CLK,
   input  logic                                        RST,
   input  logic [(TX_CONTENT_BUFFER_BYTE_SIZE-1)*8-1:0] tx_text_bytes,
   input  logic [TX_CONTENT_BUFFER_INDEX_SIZE-1:0]     tx_text_size,
   input  logic                                        tx_text_valid,
   output logic                                        tx_text_ready,
   output logic [7:0]                                  tx_chunk_type,
   output logic [TX_CONTENT_BUFFER_BYTE_SIZE*8-1:0]    tx_chunk_bytes,
   output logic [TX_CONTENT_BUFFER_INDEX_SIZE-1:0]     tx_chunk_byte_size,
   output logic                                        tx_is_chunk_ready,
   input  logic                                        tx_chunk_ack,
   output logic                                        tx_text_rejected,
   output logic [7:0]                                  tx_text_reject_count
);

   localparam int BS = TX_CONTENT_BUFFER_BYTE_SIZE;
   localparam int IW = TX_CONTENT_BUFFER_INDEX_SIZE;
   localparam int TW = (BS - 1) * 8;
   localparam int CW = BS * 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUILD = 2'd1,
      ST_SEND  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   text_q, text_d;
   logic [IW-1:0]   size_q, size_d;
   logic [CW-1:0]   chunk_q, chunk_d;
   logic [IW-1:0]   chunk_size_q, chunk_size_d;
   logic            rejected_q, rejected_d;
   logic [7:0]      reject_count_q, reject_count_d;
   logic            too_big;

   // Full-width compare so sizes like 0x102 are not mistaken for 2.
   assign too_big = (tx_text_size > IW'(TX_TEXT_MAX_SIZE));

   always_comb begin
      state_d           = state_q;
      text_d            = text_q;
      size_d            = size_q;
      chunk_d           = chunk_q;
      chunk_size_d      = chunk_size_q;
      rejected_d        = 1'b0;
      reject_count_d    = reject_count_q;
      tx_text_ready     = 1'b0;
      tx_is_chunk_ready = 1'b0;

      case (state_q)
         ST_IDLE: begin
            tx_text_ready = 1'b1;
            if (tx_text_valid) begin
               if (too_big) begin
                  rejected_d = 1'b1;
                  if (reject_count_q != 8'hFF) begin
                     reject_count_d = reject_count_q + 8'd1;
                  end
               end else begin
                  text_d  = tx_text_bytes;
                  size_d  = tx_text_size;
                  state_d = ST_BUILD;
               end
            end
         end
         ST_BUILD: begin
            chunk_d      = '0;
            chunk_d[7:0] = size_q[7:0];
            // Text bytes beyond the length are masked to zero, never passed through.
            for (int k = 1; k < BS; k++) begin
               if (IW'(k) <= size_q) begin
                  chunk_d[8*k +: 8] = text_q[8*(k-1) +: 8];
               end
            end
            chunk_size_d = size_q + IW'(1);
            state_d      = ST_SEND;
         end
         ST_SEND: begin
            tx_is_chunk_ready = 1'b1;
            if (tx_chunk_ack) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q        <= ST_IDLE;
         text_q         <= '0;
         size_q         <= '0;
         chunk_q        <= '0;
         chunk_size_q   <= '0;
         rejected_q     <= 1'b0;
         reject_count_q <= 8'h00;
      end else begin
         state_q        <= state_d;
         text_q         <= text_d;
         size_q         <= size_d;
         chunk_q        <= chunk_d;
         chunk_size_q   <= chunk_size_d;
         rejected_q     <= rejected_d;
         reject_count_q <= reject_count_d;
      end
   end

   assign tx_chunk_type        = INTERFACE_TX_CHUNK_TYPE;
   assign tx_chunk_bytes       = chunk_q;
   assign tx_chunk_byte_size   = chunk_size_q;
   assign tx_text_rejected     = rejected_q;
   assign tx_text_reject_count = reject_count_q;

endmodule

// File: tb/tb_v_tx_text.sv
// Bench for v_tx_text: timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, and a randomized request stream.
module tb_v_tx_text;

   localparam int TW = 256;
   localparam int CW = 264;

   logic            CLK = 1'b0;
   logic            RST;
   logic [TW-1:0]   tx_text_bytes;
   logic [31:0]     tx_text_size;
   logic            tx_text_valid;
   logic            tx_text_ready;
   logic [7:0]      tx_chunk_type;
   logic [CW-1:0]   tx_chunk_bytes;
   logic [31:0]     tx_chunk_byte_size;
   logic            tx_is_chunk_ready;
   logic            tx_chunk_ack;
   logic            tx_text_rejected;
   logic [7:0]      tx_text_reject_count;

   always #5 CLK = ~CLK;

   v_tx_text dut (
      .CLK                  (CLK),
      .RST                  (RST),
      .tx_text_bytes        (tx_text_bytes),
      .tx_text_size         (tx_text_size),
      .tx_text_valid        (tx_text_valid),
      .tx_text_ready        (tx_text_ready),
      .tx_chunk_type        (tx_chunk_type),
      .tx_chunk_bytes       (tx_chunk_bytes),
      .tx_chunk_byte_size   (tx_chunk_byte_size),
      .tx_is_chunk_ready    (tx_is_chunk_ready),
      .tx_chunk_ack         (tx_chunk_ack),
      .tx_text_rejected     (tx_text_rejected),
      .tx_text_reject_count (tx_text_reject_count)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Chunk as the text format defines it: length byte, text, zero fill.
   function automatic logic [CW-1:0] encode(input logic [TW-1:0] t, input logic [31:0] n);
      logic [CW-1:0] r;
      r      = '0;
      r[7:0] = n[7:0];
      for (int k = 0; k < int'(n); k++) r[8*(k+1) +: 8] = t[8*k +: 8];
      return r;
   endfunction

   // Reference model: remembers the edge a request was accepted and the edge the
   // ack was taken; everything observable is derived from those timestamps.
   int            e = 0;
   bit            busy = 1'b0;
   int            m_acc = 0;
   int            m_ack = -1;
   logic [CW-1:0] m_bytes = '0;
   logic [CW-1:0] pend_bytes = '0;
   logic [31:0]   m_size = '0;
   logic [31:0]   pend_size = '0;
   logic [7:0]    m_count = '0;
   bit            m_rej = 1'b0;
   bit            chk_en = 1'b0;

   always @(posedge CLK) begin
      e++;
      m_rej = 1'b0;
      if (RST) begin
         busy    = 1'b0;
         m_ack   = -1;
         m_bytes = '0;
         m_size  = '0;
         m_count = '0;
         chk_en  = 1'b1;
      end else if (busy) begin
         if (m_ack >= 0 && e == m_ack + 1) busy = 1'b0;
         else if (e == m_acc + 1) begin
            m_bytes = pend_bytes;
            m_size  = pend_size + 32'd1;
         end else if (m_ack < 0 && tx_chunk_ack) m_ack = e;
      end else if (tx_text_valid) begin
         if (tx_text_size > 32'd32) begin
            m_rej = 1'b1;
            if (m_count != 8'd255) m_count = m_count + 8'd1;
         end else begin
            busy       = 1'b1;
            m_acc      = e;
            m_ack      = -1;
            pend_bytes = encode(tx_text_bytes, tx_text_size);
            pend_size  = tx_text_size;
         end
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         check("text_ready",   CW'(tx_text_ready),        CW'(!busy));
         check("chunk_ready",  CW'(tx_is_chunk_ready),    CW'(busy && e >= m_acc + 1 && m_ack < 0));
         check("chunk_type",   CW'(tx_chunk_type),        CW'(8'd5));
         check("chunk_bytes",  tx_chunk_bytes,            m_bytes);
         check("chunk_size",   CW'(tx_chunk_byte_size),   CW'(m_size));
         check("rejected",     CW'(tx_text_rejected),     CW'(m_rej));
         check("reject_count", CW'(tx_text_reject_count), CW'(m_count));
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_chunk(input int budget);
      int n = 0;
      while (!tx_is_chunk_ready && n < budget) begin
         tick();
         n++;
      end
      check("wait_chunk_ready", CW'(tx_is_chunk_ready), CW'(1'b1));
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (!tx_text_ready && n < budget) begin
         tick();
         n++;
      end
      check("wait_text_ready", CW'(tx_text_ready), CW'(1'b1));
   endtask

   task automatic send(input logic [TW-1:0] t, input logic [31:0] n, input int ack_delay);
      tx_text_bytes = t;
      tx_text_size  = n;
      tx_text_valid = 1'b1;
      tick();
      tx_text_valid = 1'b0;
      if (n <= 32'd32) begin
         wait_chunk(10);
         repeat (ack_delay) tick();
         tx_chunk_ack = 1'b1;
         tick();
         tx_chunk_ack = 1'b0;
         wait_idle(10);
      end
   endtask

   function automatic logic [TW-1:0] rand_text();
      logic [TW-1:0] t;
      for (int i = 0; i < 8; i++) t[32*i +: 32] = $urandom;
      return t;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [TW-1:0] ta, tb2;
      logic [31:0]   n;

      RST           = 1'b1;
      tx_text_bytes = '0;
      tx_text_size  = '0;
      tx_text_valid = 1'b0;
      tx_chunk_ack  = 1'b0;
      repeat (3) tick();
      RST = 1'b0;
      check("rst_text_ready",  CW'(tx_text_ready),        CW'(1'b1));
      check("rst_chunk_ready", CW'(tx_is_chunk_ready),    CW'(1'b0));
      check("rst_type",        CW'(tx_chunk_type),        CW'(8'd5));
      check("rst_bytes",       tx_chunk_bytes,            '0);
      check("rst_count",       CW'(tx_text_reject_count), CW'(8'd0));
      tick();

      // "HI" with garbage above, ack held high from the request onward
      ta            = '1;
      ta[15:0]      = 16'h4948;
      tx_text_bytes = ta;
      tx_text_size  = 32'd2;
      tx_text_valid = 1'b1;
      tx_chunk_ack  = 1'b1;
      tick();
      tx_text_valid = 1'b0;
      check("t1_ready_n1", CW'(tx_text_ready),     CW'(1'b0));
      check("t1_chunk_n1", CW'(tx_is_chunk_ready), CW'(1'b0));
      tick();
      check("t1_chunk_n2", CW'(tx_is_chunk_ready),   CW'(1'b1));
      check("t1_low24",    CW'(tx_chunk_bytes[23:0]), CW'(24'h494802));
      check("t1_high",     CW'(tx_chunk_bytes[263:24]), '0);
      check("t1_size",     CW'(tx_chunk_byte_size),  CW'(32'd3));
      tick();
      check("t1_chunk_n3", CW'(tx_is_chunk_ready), CW'(1'b0));
      check("t1_ready_n3", CW'(tx_text_ready),     CW'(1'b0));
      tick();
      check("t1_ready_n4", CW'(tx_text_ready), CW'(1'b1));
      tx_chunk_ack = 1'b0;

      // Maximum size, then one over
      send({32{8'h41}}, 32'd32, 2);
      check("t2_size",  CW'(tx_chunk_byte_size),    CW'(32'd33));
      check("t2_byte0", CW'(tx_chunk_bytes[7:0]),   CW'(8'h20));
      check("t2_text",  CW'(tx_chunk_bytes[263:8]), CW'({32{8'h41}}));
      tx_text_size  = 32'd33;
      tx_text_valid = 1'b1;
      tick();
      tx_text_valid = 1'b0;
      check("t2_rej_pulse", CW'(tx_text_rejected),     CW'(1'b1));
      check("t2_rej_count", CW'(tx_text_reject_count), CW'(8'd1));
      tick();
      check("t2_rej_end",   CW'(tx_text_rejected),   CW'(1'b0));
      check("t2_no_chunk",  CW'(tx_chunk_byte_size), CW'(32'd33));

      // Empty text
      send(rand_text(), 32'd0, 1);
      check("t3_bytes", tx_chunk_bytes,          '0);
      check("t3_size",  CW'(tx_chunk_byte_size), CW'(32'd1));

      // Delayed ack with a second request held pending
      ta            = rand_text();
      tb2           = rand_text();
      tx_text_bytes = ta;
      tx_text_size  = 32'd5;
      tx_text_valid = 1'b1;
      tick();
      tx_text_bytes = tb2;
      tx_text_size  = 32'd7;
      wait_chunk(10);
      repeat (10) begin
         check("t4_busy", CW'(tx_text_ready), CW'(1'b0));
         tick();
      end
      check("t4_hold", tx_chunk_bytes, encode(ta, 32'd5));
      tx_chunk_ack = 1'b1;
      tick();
      tx_chunk_ack = 1'b0;
      check("t4_done_busy", CW'(tx_text_ready), CW'(1'b0));
      check("t4_done_hold", tx_chunk_bytes,     encode(ta, 32'd5));
      tick();
      wait_chunk(10);
      tx_text_valid = 1'b0;
      check("t4_second", tx_chunk_bytes, encode(tb2, 32'd7));
      tx_chunk_ack = 1'b1;
      tick();
      tx_chunk_ack = 1'b0;
      wait_idle(10);

      // Reset while presenting a chunk
      tx_text_bytes = rand_text();
      tx_text_size  = 32'd4;
      tx_text_valid = 1'b1;
      tick();
      tx_text_valid = 1'b0;
      wait_chunk(10);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("t5_chunk", CW'(tx_is_chunk_ready),    CW'(1'b0));
      check("t5_bytes", tx_chunk_bytes,            '0);
      check("t5_size",  CW'(tx_chunk_byte_size),   CW'(32'd0));
      check("t5_count", CW'(tx_text_reject_count), CW'(8'd0));
      ta = rand_text();
      send(ta, 32'd3, 0);
      check("t5_after", tx_chunk_bytes, encode(ta, 32'd3));

      // Random stream, including sizes whose low byte looks legal
      for (int i = 0; i < 60; i++) begin
         n = 32'($urandom_range(0, 40));
         if ($urandom_range(0, 7) == 0) n = 32'h100 | 32'($urandom_range(0, 32));
         repeat ($urandom_range(0, 2)) tick();
         send(rand_text(), n, int'($urandom_range(0, 3)));
      end

      // Saturation of the reject counter
      tx_text_size  = 32'hFFFF_FFFF;
      tx_text_valid = 1'b1;
      repeat (300) tick();
      tx_text_valid = 1'b0;
      check("t6_last_pulse", CW'(tx_text_rejected), CW'(1'b1));
      tick();
      check("t6_count", CW'(tx_text_reject_count), CW'(8'd255));
      repeat (2) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
